// File: rtl/wb_arbiter.sv
// Write-back arbiter: merges execute results and load results onto the single
// register-file write port, queueing execute results that lose arbitration.
module wb_arbiter #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DEPTH  = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       alu_valid,
    input  logic [ADDR_W-1:0]          alu_rd,
    input  logic [DATA_W-1:0]          alu_data,
    output logic                       alu_stall,
    input  logic                       ld_valid,
    input  logic [ADDR_W-1:0]          ld_rd,
    input  logic [DATA_W-1:0]          ld_data,
    output logic                       ld_ready,
    output logic [ADDR_W-1:0]          wr_add,
    output logic [DATA_W-1:0]          wr_data,
    output logic                       wr_enable,
    output logic [$clog2(DEPTH+1)-1:0] fifo_cnt
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned PTR_W = $clog2(DEPTH);

    typedef struct packed {
        logic [ADDR_W-1:0] rd;
        logic [DATA_W-1:0] data;
    } entry_t;

    entry_t             fifoMem [DEPTH];
    logic [PTR_W-1:0]   rdPtr;
    logic [PTR_W-1:0]   wrPtr;
    logic               full;
    logic               fifoPush;
    logic               fifoPop;
    logic               wrNext;
    entry_t             aluEntry;
    entry_t             ldEntry;
    entry_t             headEntry;
    entry_t             wrEntry;

    // Circular pointer advance; DEPTH need not be a power of two.
    function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
    endfunction

    assign full      = (fifo_cnt == CNT_W'(DEPTH));
    assign alu_stall = full;
    assign ld_ready  = !full;

    assign aluEntry  = '{rd: alu_rd, data: alu_data};
    assign ldEntry   = '{rd: ld_rd,  data: ld_data};
    assign headEntry = fifoMem[rdPtr];

    // Priority: drain when full, then load, then queued execute, then bypass.
    always_comb begin
        fifoPush = 1'b0;
        fifoPop  = 1'b0;
        wrNext   = 1'b0;
        wrEntry  = headEntry;
        if (full) begin
            fifoPop = 1'b1;
            wrNext  = 1'b1;
        end else if (ld_valid) begin
            wrNext   = 1'b1;
            wrEntry  = ldEntry;
            fifoPush = alu_valid;
        end else if (fifo_cnt != '0) begin
            fifoPop  = 1'b1;
            wrNext   = 1'b1;
            fifoPush = alu_valid;
        end else if (alu_valid) begin
            wrNext  = 1'b1;
            wrEntry = aluEntry;
        end
    end

    // Queue storage carries no reset; validity is tracked by the count.
    always_ff @(posedge clk) begin
        if (fifoPush) begin
            fifoMem[wrPtr] <= aluEntry;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdPtr    <= '0;
            wrPtr    <= '0;
            fifo_cnt <= '0;
        end else begin
            if (fifoPush) begin
                wrPtr <= nextPtr(wrPtr);
            end
            if (fifoPop) begin
                rdPtr <= nextPtr(rdPtr);
            end
            fifo_cnt <= fifo_cnt + CNT_W'(fifoPush) - CNT_W'(fifoPop);
        end
    end

    // Address/data hold their last value while idle; only wr_enable qualifies them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_enable <= 1'b0;
            wr_add    <= '0;
            wr_data   <= '0;
        end else begin
            wr_enable <= wrNext;
            if (wrNext) begin
                wr_add  <= wrEntry.rd;
                wr_data <= wrEntry.data;
            end
        end
    end

endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Write-back arbiter sitting directly upstream of the 32×32 register file. It merges two result producers into the register file's single write port (write address, write data, write enable):
- the execute stage, which delivers one result per cycle and cannot be back-pressured mid-cycle;
- the load unit, which uses a valid/ready handshake.

Execute results that lose arbitration are held in a small FIFO. Exactly one register write is issued per cycle, at most.

## Interface
- DATA_W, 32, result/register data width
- ADDR_W, 5, register address width
- DEPTH, 2, execute-result FIFO depth (legal 2..8)

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high; clock clk
- alu_valid  in  1  execute result present this cycle
- alu_rd  in  ADDR_W  execute destination register
- alu_data  in  DATA_W  execute result
- alu_stall  out  1  FIFO full; execute must hold its result, and alu_valid is ignored
- ld_valid  in  1  load result offered
- ld_rd  in  ADDR_W  load destination register
- ld_data  in  DATA_W  load data
- ld_ready  out  1  load result accepted this cycle when ld_valid=1
- wr_add  out  ADDR_W  register-file write address (registered)
- wr_data  out  DATA_W  register-file write data (registered)
- wr_enable  out  1  register-file write enable (registered)
- fifo_cnt  out  $clog2(DEPTH+1)  FIFO occupancy

## Operation
Internal signal: full = (fifo_cnt == DEPTH).
- alu_stall = full (combinational from registered count).
- ld_ready = !full.

Arbitration is evaluated each cycle, first matching rule wins:
1. **full:** pop FIFO head and write it. Load is not accepted. No push.
2. **!full, ld_valid:** write the load entry. If alu_valid, push the execute entry.
3. **!full, !ld_valid, fifo_cnt>0:** pop FIFO head and write it. If alu_valid, push the execute entry (simultaneous push and pop; count unchanged).
4. **fifo_cnt==0, !ld_valid, alu_valid:** bypass. Write the execute entry directly; no push.
5. **otherwise:** no write; wr_enable=0 next cycle.

Rules and guarantees:
- FIFO is strictly in-order, with circular read/write pointers that wrap modulo DEPTH.
- The count never exceeds DEPTH and never underflows.
- Load has priority except when the FIFO is full. Because rule 1 blocks pushes, the next cycle has count DEPTH-1, so a waiting load is served. Load starvation is therefore bounded to 1 cycle per full event.
- Ordering between the two sources is not guaranteed. Same-rd ordering across sources is the hazard unit's responsibility; this block does not check it.
- All register addresses, including 0, are written as presented.

Reset (rst=1, asynchronous):
- wr_enable=0, wr_add=0, wr_data=0.
- FIFO pointers and count = 0, so alu_stall=0 and ld_ready=1.
- FIFO storage contents are don't-care.
- Asserting rst mid-operation discards all queued entries and any in-flight write. No write is issued in the cycle following reset deassertion unless the rules above select one.

## Timing
- Latency is measured from the edge at which the input is sampled to the cycle in which wr_enable is high.
  - Bypass execute result and accepted load: 1 cycle. The result is sampled at edge N and appears on wr_* after edge N, so the register file writes it at edge N+1.
  - Queued execute result: 1 cycle after the edge at which it is popped.
- The load handshake completes on the edge where ld_valid & ld_ready = 1. ld_ready does not depend on ld_valid.
- alu_stall and ld_ready are valid shortly after each clock edge. There is no combinational path from any input to any output.
- Throughput: exactly one write per cycle whenever any source has data.

## Test plan
- **Reset:** hold rst 3 cycles with alu_valid=1 -> wr_enable=0, fifo_cnt=0, ld_ready=1 throughout; after release, alu_rd=3, alu_data=0x11 -> next cycle wr_add=3, wr_data=0x11, wr_enable=1.
- **Collision:** same cycle ld_valid (rd=4, 0xAAAA) and alu_valid (rd=5, 0xBBBB) -> cycle+1 writes r4=0xAAAA, fifo_cnt=1; cycle+2 writes r5=0xBBBB, fifo_cnt=0.
- **Fill and stall:** ld_valid held high with rd=7 and alu_valid every cycle -> after 2 cycles fifo_cnt=2, alu_stall=1, ld_ready=0; next write is the oldest ALU entry; following cycle ld_ready=1 and the load is written; write order matches FIFO order.
- **Push+pop and wrap:** fifo_cnt=1; drive alu_valid for 10 cycles, ld_valid=0 -> count stays 1, writes appear in issue order with no loss or duplication across pointer wrap.
- **Reset mid-operation:** fifo_cnt=2, assert rst asynchronously between edges -> wr_enable drops immediately, fifo_cnt=0; the two queued entries are never written after release.
- **Idle:** no valids -> wr_enable=0 every cycle; wr_add/wr_data may hold stale values, and the bench must not check them while wr_enable=0.
